ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- Works in the opposite direction to the existing keyboard receiver and shares the PS2_KBCLK/PS2_KBDAT open-collector lines with it.
- Runs on CLOCK_50. The receiver is held off while `busy`=1.

---
 rtl/ps2_host_tx_pkg.sv | 20 ++
 rtl/ps2_host_tx_line_filter.sv | 35 +++
 rtl/ps2_host_tx.sv | 136 +++++++++++++
 tb/tb_ps2_host_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 definitions (states, command bytes, default timing, parity helper)
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    DATA      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_FILTER_LEN     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, FILTER_LEN glitch filter and falling-edge pulse for one PS/2 line
// Ports: i_clk, i_reset (async, active-high), i_pin raw pin level,
//        o_level filtered level, o_fall one-cycle pulse on filtered 1->0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);
  localparam int CW = $clog2(FILTER_LEN) + 1;
  logic r_s1, r_s2, r_lvl, r_fall;
  logic [CW-1:0] r_cnt;
  logic w_diff, w_flip;
  assign w_diff = r_s2 != r_lvl;
  assign w_flip = w_diff && r_cnt == CW'(FILTER_LEN - 1);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_lvl  <= 1'b1;
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_pin;
      r_s2   <= r_s1;
      r_cnt  <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
      r_lvl  <= w_flip ? r_s2 : r_lvl;
      r_fall <= w_flip & r_lvl;
    end
  assign o_level = r_lvl;
  assign o_fall  = r_fall;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter sending one command byte to the keyboard
// Ports: i_clk, i_reset (async, active-high), i_tx_data/i_tx_start request,
//        i_ps2c_in/i_ps2d_in raw pins, o_ps2c_oe/o_ps2d_oe open-collector pull-downs,
//        o_busy, o_tx_done / o_tx_err one-cycle result pulses.
// Optional macro PS2_TX_TIMEOUT_EN adds a watchdog that aborts stalled transfers.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
`ifdef PS2_TX_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_start,
  input  logic       i_ps2c_in,
  input  logic       i_ps2d_in,
  output logic       o_ps2c_oe,
  output logic       o_ps2d_oe,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx_err
);
  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  state_t r_state;
  logic [8:0] r_sr;
  logic [3:0] r_bit;
  logic [IW-1:0] r_inh;
  logic r_ack, r_c_oe, r_d_oe, r_busy, r_done, r_err;
  logic w_clk, w_dat, w_fall, w_unused_dfall;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_ps2c_in), .o_level(w_clk), .o_fall(w_fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_ps2d_in), .o_level(w_dat), .o_fall(w_unused_dfall)
  );
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_wd;
  logic w_timeout;
  assign w_timeout = (r_state == RTS || r_state == DATA || r_state == ACK) && r_wd == TW'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_bit   <= '0;
      r_inh   <= '0;
      r_ack   <= 1'b0;
      r_c_oe  <= 1'b0;
      r_d_oe  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      r_wd    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      r_wd   <= w_fall ? '0 : r_wd + 1'b1;
`endif
      case (r_state)
        IDLE:
          if (i_tx_start) begin
            r_sr    <= {odd_parity(i_tx_data), i_tx_data};
            r_bit   <= '0;
            r_inh   <= '0;
            r_c_oe  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= INHIBIT;
          end
        INHIBIT: begin
          r_inh <= r_inh + 1'b1;
          // start bit goes low one cycle before the clock is released
          if (r_inh >= IW'(INHIBIT_CYCLES - 2)) r_d_oe <= 1'b1;
          if (r_inh == IW'(INHIBIT_CYCLES - 1)) begin
            r_c_oe  <= 1'b0;
            r_state <= RTS;
`ifdef PS2_TX_TIMEOUT_EN
            r_wd    <= '0;
`endif
          end
        end
        RTS:
          if (w_fall) begin
            r_d_oe  <= ~r_sr[0];
            r_sr    <= r_sr >> 1;
            r_bit   <= 4'd1;
            r_state <= DATA;
          end
        DATA:
          if (w_fall) begin
            if (r_bit == 4'd9) begin
              r_d_oe  <= 1'b0;
              r_state <= ACK;
            end else begin
              r_d_oe <= ~r_sr[0];
              r_sr   <= r_sr >> 1;
              r_bit  <= r_bit + 1'b1;
            end
          end
        ACK:
          if (w_fall) begin
            r_ack   <= ~w_dat;
            r_state <= WAIT_IDLE;
          end
        WAIT_IDLE:
          if (w_clk && w_dat) begin
            r_done  <= r_ack;
            r_err   <= ~r_ack;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      if (w_timeout) begin
        r_c_oe  <= 1'b0;
        r_d_oe  <= 1'b0;
        r_err   <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= IDLE;
      end
`endif
    end
  assign o_ps2c_oe = r_c_oe;
  assign o_ps2d_oe = r_d_oe;
  assign o_busy    = r_busy;
  assign o_tx_done = r_done;
  assign o_tx_err  = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model driving the open-collector lines
module tb_ps2_host_tx;
  localparam int INH = 5000, FLT = 8, TO = 3000, HALF = 100;
  logic clk = 1'b0, i_reset = 1'b1, i_tx_start = 1'b0;
  logic [7:0] i_tx_data = 8'h00;
  logic dev_c = 1'b0, dev_d = 1'b0;
  logic c_line, d_line;
  logic o_ps2c_oe, o_ps2d_oe, o_busy, o_tx_done, o_tx_err;
  int checks = 0, errors = 0;
  int run = 0, last_run = 0, inh_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic prev_c = 1'b0;
  logic f_ok, f_start;
  logic [9:0] f_bits;
  assign c_line = ~(o_ps2c_oe | dev_c);
  assign d_line = ~(o_ps2d_oe | dev_d);
  always #10 clk = ~clk;
  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
`ifdef PS2_TX_TIMEOUT_EN
    .TIMEOUT_CYCLES(TO),
`endif
    .FILTER_LEN(FLT)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_tx_data(i_tx_data), .i_tx_start(i_tx_start),
    .i_ps2c_in(c_line), .i_ps2d_in(d_line), .o_ps2c_oe(o_ps2c_oe), .o_ps2d_oe(o_ps2d_oe),
    .o_busy(o_busy), .o_tx_done(o_tx_done), .o_tx_err(o_tx_err)
  );
  always @(negedge clk) begin
    if (o_ps2c_oe) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run <= 0;
    end
    if (o_ps2c_oe && !prev_c) inh_cnt <= inh_cnt + 1;
    prev_c <= o_ps2c_oe;
    if (o_tx_done) done_cnt <= done_cnt + 1;
    if (o_tx_err) err_cnt <= err_cnt + 1;
    if (o_tx_done && o_tx_err) both_cnt <= both_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    check("busy_idle", o_busy, 0);
    i_tx_data = d;
    i_tx_start = 1'b1;
    @(negedge clk);
    i_tx_start = 1'b0;
    check("busy_rise", o_busy, 1);
  endtask
  task automatic dev_frame(input int n, input logic ack);
    f_bits = '0;
    for (int i = 0; i < 20 && !o_ps2c_oe; i++) @(negedge clk);
    for (int i = 0; i < INH + 100 && o_ps2c_oe; i++) @(negedge clk);
    f_ok = !o_ps2c_oe;
    f_start = d_line;
    repeat (20) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      dev_c = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b0;
      f_bits[k] = d_line;
      if (k == 9 && ack) dev_d = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    if (n == 10) begin
      dev_c = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_d = 1'b0;
    end
  endtask
  task automatic do_frame(input logic [7:0] d, input logic par, input logic ack, input logic pulse12);
    int d0, e0, i0;
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inh_cnt;
    fork
      begin
        send(d);
        dev_frame(10, ack);
      end
      if (pulse12) begin
        repeat (3000) @(negedge clk);
        i_tx_data = 8'h12;
        i_tx_start = 1'b1;
        @(negedge clk);
        i_tx_start = 1'b0;
      end
    join
    check("rts_seen", f_ok, 1);
    check("inhibit_len", last_run, INH);
    check("start_bit", f_start, 0);
    check("data_bits", f_bits[7:0], d);
    check("parity_bit", f_bits[8], par);
    check("stop_bit", f_bits[9], 1);
    for (int i = 0; i < 300 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("err_pulses", err_cnt - e0, ack ? 0 : 1);
    check("busy_end", o_busy, 0);
    check("c_oe_end", o_ps2c_oe, 0);
    check("d_oe_end", o_ps2d_oe, 0);
    check("inhibits", inh_cnt - i0, 1);
  endtask
  logic [7:0] vd [3] = '{8'hED, 8'h00, 8'h07};
  logic       vp [3] = '{1'b1, 1'b1, 1'b0};
  initial begin
    int i0, cnt;
    repeat (3) @(negedge clk);
    check("rst_c_oe", o_ps2c_oe, 0);
    check("rst_d_oe", o_ps2d_oe, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_tx_done, 0);
    check("rst_err", o_tx_err, 0);
    i_reset = 1'b0;
    repeat (20) @(negedge clk);
    i0 = inh_cnt;
    do_frame(8'hED, 1'b1, 1'b1, 1'b1);
    repeat (200) @(negedge clk);
    check("no_queue", inh_cnt - i0, 1);
    check("no_queue_busy", o_busy, 0);
    for (int v = 1; v < 3; v++) do_frame(vd[v], vp[v], 1'b1, 1'b0);
    do_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    send(8'h17);
    dev_frame(4, 1'b0);
    check("mid_busy", o_busy, 1);
    check("mid_d_oe", o_ps2d_oe, 1);
    @(negedge clk);
    #3 i_reset = 1'b1;
    #1;
    check("arst_c_oe", o_ps2c_oe, 0);
    check("arst_d_oe", o_ps2d_oe, 0);
    check("arst_busy", o_busy, 0);
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    repeat (30) @(negedge clk);
    do_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    send(8'h55);
    for (int i = 0; i < 20 && !o_ps2c_oe; i++) @(negedge clk);
    for (int i = 0; i < INH + 100 && o_ps2c_oe; i++) @(negedge clk);
    check("stall_rts", o_ps2c_oe, 0);
`ifdef PS2_TX_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < TO + 100 && !o_tx_err; i++) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles", (cnt >= TO - 2 && cnt <= TO + 2) ? 1 : 0, 1);
    @(negedge clk);
    check("timeout_busy", o_busy, 0);
    check("timeout_d_oe", o_ps2d_oe, 0);
`else
    cnt = 0;
    repeat (TO + 500) @(negedge clk);
    check("stall_busy", o_busy, 1);
    check("stall_d_oe", o_ps2d_oe, 1);
    check("stall_no_err", err_cnt, 1);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
`endif
    check("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
